// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: shared widths and FSM state encoding for the bit scanner.
package bit_scan_pkg;
    localparam int MASK_W = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 6;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/ctz.sv
// ctz: single-cycle trailing-zero count of a 32-bit word; returns 32 for zero.
module ctz (
    input  logic [31:0] a,
    output logic [5:0]  y
);
    always_comb begin
        y = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (a[i]) y = 6'(i);
        end
    end
endmodule

// File: rtl/bit_scan_seq.sv
// bit_scan_seq: streams the positions of the set bits of a mask, lowest first,
// over a valid/ready handshake, then pulses done with the delivered count.
module bit_scan_seq
    import bit_scan_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [MASK_W-1:0] mask,
    input  logic              abort,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [IDX_W-1:0]  idx,
    output logic              idx_last,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);
    state_t            state_q, state_d;
    logic [MASK_W-1:0] rem_q, rem_d, rem_lo;
    logic [CNT_W-1:0]  count_q, count_d, ctz_y;
    logic              xfer;

    ctz u_ctz (.a(rem_q), .y(ctz_y));

    assign rem_lo      = rem_q & (rem_q - MASK_W'(1));
    assign start_ready = state_q == IDLE;
    assign idx_valid   = state_q == SCAN;
    assign done        = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign idx         = ctz_y[IDX_W-1:0];
    assign idx_last    = rem_lo == '0;
    assign count       = count_q;
    assign xfer        = idx_valid && idx_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    rem_d   = mask;
                    count_d = '0;
                    state_d = (mask != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (xfer) begin
                    rem_d   = rem_lo;
                    count_d = count_q + CNT_W'(1);
                end
                // an empty rem cannot occur in SCAN; leave cleanly if it ever does
                if (abort) state_d = IDLE;
                else if ((xfer && idx_last) || ctz_y[IDX_W]) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_bit_scan_seq.sv
// tb_bit_scan_seq: directed vector table plus hand-written sequences for the
// full-mask, mid-scan reset and stall corner cases.
module tb_bit_scan_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] mask;
    logic        abort;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic        idx_last;
    logic        done;
    logic [5:0]  count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit_scan_seq dut (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
        .mask(mask), .abort(abort), .idx_valid(idx_valid), .idx_ready(idx_ready),
        .idx(idx), .idx_last(idx_last), .done(done), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] m;
        logic        ab;
        logic        rdy;
        logic        v;
        logic [4:0]  ix;
        logic        last;
        logic        dn;
        logic [5:0]  cnt;
        logic        sr;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] m, input logic ab, input logic rdy);
        start_valid = sv;
        mask        = m;
        abort       = ab;
        idx_ready   = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [4:0] ix, input logic last,
                             input logic dn, input logic [5:0] cnt, input logic sr, input logic bsy);
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(v));
        if (v) begin
            chk({tag, ".idx"}, 32'(idx), 32'(ix));
            chk({tag, ".idx_last"}, 32'(idx_last), 32'(last));
        end
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".start_ready"}, 32'(start_ready), 32'(sr));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        drive(0, 32'h0, 0, 0);
        reset_n = 1'b0;
        #12;
        chk_state("reset", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        //            sv  mask          ab rdy  v  idx last dn cnt sr bsy
        vecs.push_back('{1, 32'h8000_0011, 0, 1,  1, 0,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  1, 4,  0,  0, 1,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  1, 31, 1,  0, 2,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  1, 3,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  0, 3,  1, 0});
        vecs.push_back('{1, 32'h0,         0, 1,  0, 0,  0,  1, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  0, 0,  1, 0});
        vecs.push_back('{1, 32'h0000_0104, 0, 0,  1, 2,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 0,  1, 2,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 0,  1, 2,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 0,  1, 2,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  1, 8,  1,  0, 1,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  1, 2,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  0, 2,  1, 0});
        vecs.push_back('{1, 32'h0000_00F0, 0, 1,  1, 4,  0,  0, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         1, 1,  0, 0,  0,  0, 1,  1, 0});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  0, 1,  1, 0});
        vecs.push_back('{1, 32'h0,         1, 1,  0, 0,  0,  1, 0,  0, 1});
        vecs.push_back('{0, 32'h0,         1, 1,  0, 0,  0,  0, 0,  1, 0});
        vecs.push_back('{1, 32'h0000_0003, 0, 0,  1, 0,  0,  0, 0,  0, 1});
        vecs.push_back('{1, 32'h0000_FFFF, 0, 1,  1, 1,  1,  0, 1,  0, 1});
        vecs.push_back('{1, 32'h0000_FFFF, 0, 1,  0, 0,  0,  1, 2,  0, 1});
        vecs.push_back('{0, 32'h0,         0, 1,  0, 0,  0,  0, 2,  1, 0});

        foreach (vecs[k]) begin
            drive(vecs[k].sv, vecs[k].m, vecs[k].ab, vecs[k].rdy);
            step();
            chk_state($sformatf("vec%0d", k), vecs[k].v, vecs[k].ix, vecs[k].last,
                      vecs[k].dn, vecs[k].cnt, vecs[k].sr, vecs[k].bsy);
        end

        drive(1, 32'hFFFF_FFFF, 0, 1);
        step();
        drive(0, 32'h0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            chk_state($sformatf("full%0d", i), 1, 5'(i), i == 31, 0, 6'(i), 0, 1);
            step();
        end
        chk_state("full_done", 0, 0, 0, 1, 32, 0, 1);
        step();
        chk_state("full_idle", 0, 0, 0, 0, 32, 1, 0);

        drive(1, 32'h0F0F_0000, 0, 1);
        step();
        drive(0, 32'h0, 0, 1);
        chk_state("rst_scan0", 1, 16, 0, 0, 0, 0, 1);
        step();
        chk_state("rst_scan1", 1, 17, 0, 0, 1, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_state("rst_async", 0, 0, 0, 0, 0, 1, 0);
        step();
        chk_state("rst_held", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 32'h0000_0081, 0, 1);
        step();
        drive(0, 32'h0, 0, 1);
        chk_state("post_rst0", 1, 0, 0, 0, 0, 0, 1);
        step();
        chk_state("post_rst1", 1, 7, 1, 0, 1, 0, 1);
        step();
        chk_state("post_rst_done", 0, 0, 0, 1, 2, 0, 1);
        step();
        chk_state("post_rst_idle", 0, 0, 0, 0, 2, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
